// File: rtl/bus_mem_responder_pkg.sv
// Shared constants for the bus memory responder: RISC-V funct3 access
// size/sign codes and the responder FSM state encoding.
package bus_mem_responder_pkg;

  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b010;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bus_mem_responder_if.sv
// CPU load/store/fetch bus between the CPU (master) and a memory responder (slave).
interface bus_mem_responder_if;

  logic        i_bus_DV;
  logic [31:0] i_bus_address;
  logic [31:0] i_bus_data;
  logic [2:0]  i_bhw;
  logic        i_write_notread;
  logic [31:0] o_bus_data;
  logic        o_bus_DV;
  logic        o_err;
  logic        o_busy;
  logic        o_overrun;

  modport master (
    output i_bus_DV, i_bus_address, i_bus_data, i_bhw, i_write_notread,
    input  o_bus_data, o_bus_DV, o_err, o_busy, o_overrun
  );

  modport slave (
    input  i_bus_DV, i_bus_address, i_bus_data, i_bhw, i_write_notread,
    output o_bus_data, o_bus_DV, o_err, o_busy, o_overrun
  );

endinterface

// File: rtl/bus_mem_array.sv
// Word-organised RAM: synchronous byte-enable write, combinational read of
// the word at the supplied index.
module bus_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: storage arrays get no reset; clearing a RAM needs a write sweep, not a reset branch.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/bus_mem_responder.sv
// RAM responder on the CPU bus: captures a request, waits WAIT_STATES cycles,
// then answers with a one-cycle o_bus_DV carrying read data or a write ack.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  bus_mem_responder_if.slave bus
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  state_t      state, state_n;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q, data_q;
  logic [2:0]  bhw_q;
  logic        wnr_q;
  logic        overrun_q;

  logic [31:0] offset, rdata, shifted, rd_ext, wdata;
  logic [3:0]  be;
  logic        range_err, size_err, align_err, err, resp;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      bhw_q     <= '0;
      wnr_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && bus.i_bus_DV) begin
        addr_q   <= bus.i_bus_address;
        data_q   <= bus.i_bus_data;
        bhw_q    <= bus.i_bhw;
        wnr_q    <= bus.i_write_notread;
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (state != ST_IDLE && bus.i_bus_DV) overrun_q <= 1'b1;
    end
  end

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (bus.i_bus_DV) state_n = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'(WAIT_STATES - 1)) state_n = ST_RESP;
      default: state_n = ST_IDLE;
    endcase
  end

  // Decode and legality of the captured request.
  always_comb begin
    offset    = addr_q - ADDR_BASE;
    range_err = {1'b0, offset} >= LIMIT;
    size_err  = 1'b0;
    align_err = 1'b0;
    case (bhw_q)
      BHW_B:          ;
      BHW_H:          align_err = addr_q[0];
      BHW_W:          align_err = addr_q[1:0] != 2'b00;
      BHW_BU:         size_err  = wnr_q;
      BHW_HU: begin
        size_err  = wnr_q;
        align_err = addr_q[0];
      end
      default:        size_err  = 1'b1;
    endcase
    err = range_err | size_err | align_err;
  end

  // Lane select with sign/zero extension for reads, lane replication and enables for writes.
  always_comb begin
    shifted = rdata >> {addr_q[1:0], 3'b000};
    rd_ext  = rdata;
    wdata   = data_q;
    be      = 4'b1111;
    case (bhw_q)
      BHW_B:  rd_ext = {{24{shifted[7]}}, shifted[7:0]};
      BHW_BU: rd_ext = {24'd0, shifted[7:0]};
      BHW_H:  rd_ext = {{16{shifted[15]}}, shifted[15:0]};
      BHW_HU: rd_ext = {16'd0, shifted[15:0]};
      default: ;
    endcase
    if (bhw_q == BHW_B) begin
      wdata = {4{data_q[7:0]}};
      be    = 4'b0001 << addr_q[1:0];
    end else if (bhw_q == BHW_H) begin
      wdata = {2{data_q[15:0]}};
      be    = addr_q[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign resp = (state == ST_RESP);

  bus_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (i_clk),
    .we    (resp & wnr_q & ~err),
    .be    (be),
    .idx   (offset[AW+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign bus.o_bus_DV   = resp;
  assign bus.o_err      = resp & err;
  assign bus.o_bus_data = (resp && !wnr_q && !err) ? rd_ext : 32'd0;
  assign bus.o_busy     = (state != ST_IDLE);
  assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: a vector table of load/store requests
// plus sequences for overrun and reset during an in-flight store.
module tb_bus_mem_responder;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  bus_mem_responder_if bus ();

  bus_mem_responder #(
    .ADDR_BASE  (32'h0000_0000),
    .DEPTH_WORDS(1024),
    .WAIT_STATES(2)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wnr;
    logic [2:0]  bhw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents a one-cycle request; returns at the first negedge after it is sampled.
  task automatic send(input logic wnr, input logic [2:0] bhw, input logic [31:0] addr,
                      input logic [31:0] data);
    @(negedge i_clk);
    bus.i_bus_DV        = 1'b1;
    bus.i_write_notread = wnr;
    bus.i_bhw           = bhw;
    bus.i_bus_address   = addr;
    bus.i_bus_data      = data;
    @(negedge i_clk);
    bus.i_bus_DV = 1'b0;
  endtask

  // Full transaction: latency counted in cycles from the request cycle to o_bus_DV.
  task automatic xact(input logic wnr, input logic [2:0] bhw, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rdata,
                      output logic err, output int lat);
    send(wnr, bhw, addr, data);
    lat   = 0;
    rdata = 'x;
    err   = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge i_clk);
      if (bus.o_bus_DV) begin
        lat   = i;
        rdata = bus.o_bus_data;
        err   = bus.o_err;
        break;
      end
    end
    @(negedge i_clk);
    check("dv_one_cycle", {31'd0, bus.o_bus_DV}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n_resp;

  initial begin
    bus.i_bus_DV        = 1'b0;
    bus.i_write_notread = 1'b0;
    bus.i_bhw           = 3'b000;
    bus.i_bus_address   = '0;
    bus.i_bus_data      = '0;

    vecs[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 3'b000, 32'h11,   32'h80,       32'h0,        1'b0};
    vecs[3]  = '{1'b0, 3'b000, 32'h11,   32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 3'b100, 32'h11,   32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD80EF, 1'b0};
    vecs[6]  = '{1'b0, 3'b001, 32'h13,   32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b0, 3'b010, 32'h12,   32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD80EF, 1'b0};
    vecs[9]  = '{1'b1, 3'b001, 32'h12,   32'h1234A5A5, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFFA5A5, 1'b0};
    vecs[11] = '{1'b0, 3'b101, 32'h12,   32'h0,        32'h0000A5A5, 1'b0};
    vecs[12] = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hA5A580EF, 1'b0};
    vecs[13] = '{1'b1, 3'b010, 32'h0,    32'h11223344, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1};
    vecs[15] = '{1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b1};
    vecs[16] = '{1'b0, 3'b010, 32'h0,    32'h0,        32'h11223344, 1'b0};
    vecs[17] = '{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFA5, 1'b0};
    vecs[18] = '{1'b0, 3'b011, 32'h0,    32'h0,        32'h0,        1'b1};
    vecs[19] = '{1'b1, 3'b100, 32'h0,    32'h000000FF, 32'h0,        1'b1};
    vecs[20] = '{1'b0, 3'b010, 32'h0,    32'h0,        32'h11223344, 1'b0};

    // Outputs while reset is held.
    repeat (2) @(negedge i_clk);
    check("reset_outputs", {bus.o_bus_DV, bus.o_err, bus.o_busy, bus.o_overrun, 28'd0},
          32'd0);
    check("reset_data", bus.o_bus_data, 32'd0);
    i_rst = 1'b0;

    foreach (vecs[k]) begin
      xact(vecs[k].wnr, vecs[k].bhw, vecs[k].addr, vecs[k].data, rd, er, lat);
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'd3);
      check($sformatf("vec%0d_data", k), rd, vecs[k].exp_data);
      check($sformatf("vec%0d_err", k), {31'd0, er}, {31'd0, vecs[k].exp_err});
    end
    check("no_overrun_yet", {31'd0, bus.o_overrun}, 32'd0);

    // Second strobe one cycle into the wait: ignored, single response, sticky overrun.
    send(1'b0, 3'b010, 32'h10, 32'h0);
    check("busy_in_wait", {31'd0, bus.o_busy}, 32'd1);
    bus.i_bus_DV        = 1'b1;
    bus.i_write_notread = 1'b1;
    bus.i_bus_address   = 32'h10;
    bus.i_bus_data      = 32'h0BAD0BAD;
    @(negedge i_clk);
    bus.i_bus_DV = 1'b0;
    n_resp = 0;
    rd     = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_bus_DV) begin
        n_resp++;
        rd = bus.o_bus_data;
      end
      @(negedge i_clk);
    end
    check("overrun_one_response", 32'(n_resp), 32'd1);
    check("overrun_read_data", rd, 32'hA5A580EF);
    check("overrun_sticky", {31'd0, bus.o_overrun}, 32'd1);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("overrun_no_write", rd, 32'hA5A580EF);
    check("overrun_still_set", {31'd0, bus.o_overrun}, 32'd1);

    // Reset while a store waits: the store is dropped.
    send(1'b1, 3'b010, 32'h10, 32'h55555555);
    i_rst = 1'b1;
    #1;
    check("midreset_outputs", {bus.o_bus_DV, bus.o_err, bus.o_busy, bus.o_overrun, 28'd0},
          32'd0);
    check("midreset_data", bus.o_bus_data, 32'd0);
    @(negedge i_clk);
    i_rst  = 1'b0;
    n_resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      if (bus.o_bus_DV) n_resp++;
    end
    check("midreset_no_response", 32'(n_resp), 32'd0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("midreset_old_data", rd, 32'hA5A580EF);
    check("midreset_latency", 32'(lat), 32'd3);
    check("overrun_cleared", {31'd0, bus.o_overrun}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
